// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sad_pkg
//  Description : Shared state encoding and width helpers for the SAD engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } sad_state_e;

    function automatic int score_width(input int win_bits);
        return $clog2(win_bits + 1);
    endfunction

    function automatic int pop_width(input int slice_bits);
        return $clog2(slice_bits + 1);
    endfunction

    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    localparam int WIN_BITS_DEF   = 4000;
    localparam int SLICE_BITS_DEF = 200;
    localparam int SCORE_W_DEF    = score_width(WIN_BITS_DEF);
    localparam int POP_W_DEF      = pop_width(SLICE_BITS_DEF);
    localparam int IDX_W_DEF      = idx_width(WIN_BITS_DEF / SLICE_BITS_DEF);
    localparam int MIN_INDEX_W    = 16;

endpackage
`default_nettype wire

// File: rtl/sad_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : sad_engine_if
//  Description : Template, window and score handshake bundle of the SAD engine.
//                Min-score tracking signals exist only with SAD_MIN_TRACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sad_engine_if
    import sad_pkg::*;
#(
    parameter int WIN_BITS   = WIN_BITS_DEF,
    parameter int SLICE_BITS = SLICE_BITS_DEF
);
    localparam int NSLICE  = WIN_BITS / SLICE_BITS;
    localparam int SCORE_W = score_width(WIN_BITS);
    localparam int IDX_W   = idx_width(NSLICE);

    logic                  tpl_we;
    logic [IDX_W-1:0]      tpl_addr;
    logic [SLICE_BITS-1:0] tpl_data;
    logic                  tpl_err;
    logic                  win_valid;
    logic                  win_ready;
    logic [0:WIN_BITS-1]   win_data;
    logic                  score_valid;
    logic                  score_ready;
    logic [SCORE_W-1:0]    score;
    logic                  busy;

`ifdef SAD_MIN_TRACK_EN
    logic                   frame_clr;
    logic [SCORE_W-1:0]     min_score;
    logic [MIN_INDEX_W-1:0] min_index;

    modport slave (
        input  tpl_we, tpl_addr, tpl_data, win_valid, win_data, score_ready, frame_clr,
        output tpl_err, win_ready, score_valid, score, busy, min_score, min_index
    );
    modport master (
        output tpl_we, tpl_addr, tpl_data, win_valid, win_data, score_ready, frame_clr,
        input  tpl_err, win_ready, score_valid, score, busy, min_score, min_index
    );
`else
    modport slave (
        input  tpl_we, tpl_addr, tpl_data, win_valid, win_data, score_ready,
        output tpl_err, win_ready, score_valid, score, busy
    );
    modport master (
        output tpl_we, tpl_addr, tpl_data, win_valid, win_data, score_ready,
        input  tpl_err, win_ready, score_valid, score, busy
    );
`endif

endinterface
`default_nettype wire

// File: rtl/sad_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : sad_popcount
//  Description : Combinational Hamming weight of one slice: 4-bit group counts
//                followed by a reduction of the group counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_popcount
    import sad_pkg::*;
#(
    parameter int SLICE_BITS = SLICE_BITS_DEF
) (
    input  wire  [SLICE_BITS-1:0]            i_bits,
    output logic [pop_width(SLICE_BITS)-1:0] o_count
);
    localparam int POP_W = pop_width(SLICE_BITS);
    localparam int NGRP  = (SLICE_BITS + 3) / 4;
    localparam int PADW  = NGRP * 4;

    logic [PADW-1:0] w_pad;
    logic [2:0]      w_grp [NGRP];

    assign w_pad = PADW'(i_bits);

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        assign w_grp[g] = 3'(w_pad[4*g])   + 3'(w_pad[4*g+1])
                        + 3'(w_pad[4*g+2]) + 3'(w_pad[4*g+3]);
    end

    always_comb begin
        o_count = '0;
        for (int g = 0; g < NGRP; g++) begin
            o_count = o_count + POP_W'(w_grp[g]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sad_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sad_engine
//  Description : Sequential XOR/popcount template matcher, one slice per cycle,
//                score returned over valid/ready. SAD_MIN_TRACK_EN adds
//                per-frame minimum score tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_engine
    import sad_pkg::*;
#(
    parameter int WIN_BITS   = WIN_BITS_DEF,
    parameter int SLICE_BITS = SLICE_BITS_DEF
) (
    input  wire          clk,
    input  wire          rst,
    sad_engine_if.slave  bus
);
    localparam int NSLICE  = WIN_BITS / SLICE_BITS;
    localparam int SCORE_W = score_width(WIN_BITS);
    localparam int POP_W   = pop_width(SLICE_BITS);
    localparam int IDX_W   = idx_width(NSLICE);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ACCUM = ST_ACCUM;
    localparam logic [1:0] S_HOLD  = ST_HOLD;

    if (WIN_BITS % SLICE_BITS != 0) begin : g_bad_slice
        $error("sad_engine: SLICE_BITS must divide WIN_BITS");
    end

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [SCORE_W-1:0]    r_acc;
    logic [SCORE_W-1:0]    r_score;
    logic                  r_score_valid;
    logic                  r_tpl_err;
    logic [SLICE_BITS-1:0] r_win [NSLICE];
    logic [SLICE_BITS-1:0] r_tpl [NSLICE];

    logic [SLICE_BITS-1:0] w_xor;
    logic [POP_W-1:0]      w_pop;
    logic [SCORE_W-1:0]    w_sum;
    logic                  w_last;
    logic                  w_addr_ok;
    logic                  w_capture;

    assign w_addr_ok = {1'b0, bus.tpl_addr} < (IDX_W+1)'(NSLICE);
    assign w_capture = (r_state == S_IDLE) && bus.win_valid;
    assign w_xor     = r_win[r_idx] ^ r_tpl[r_idx];
    assign w_sum     = r_acc + SCORE_W'(w_pop);
    assign w_last    = (r_idx == IDX_W'(NSLICE - 1));

    sad_popcount #(.SLICE_BITS(SLICE_BITS)) u_popcount (
        .i_bits  (w_xor),
        .o_count (w_pop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSLICE; k++) r_tpl[k] <= '0;
        end else if (bus.tpl_we && (r_state == S_IDLE) && w_addr_ok) begin
            r_tpl[bus.tpl_addr] <= bus.tpl_data;
        end
    end

    // Window is re-sliced so element b of slice k is window bit k*SLICE_BITS+b,
    // matching the template slice bit order.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < NSLICE; k++)
                for (int b = 0; b < SLICE_BITS; b++)
                    r_win[k][b] <= bus.win_data[k*SLICE_BITS + b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_acc         <= '0;
            r_score       <= '0;
            r_score_valid <= 1'b0;
            r_tpl_err     <= 1'b0;
        end else begin
            r_tpl_err <= bus.tpl_we && !((r_state == S_IDLE) && w_addr_ok);
            case (r_state)
                S_IDLE: begin
                    if (bus.win_valid) begin
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_score       <= w_sum;
                        r_score_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.score_ready) begin
                        r_score_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.win_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.score       = r_score;
    assign bus.score_valid = r_score_valid;
    assign bus.tpl_err     = r_tpl_err;

`ifdef SAD_MIN_TRACK_EN
    logic [SCORE_W-1:0]     r_min;
    logic [MIN_INDEX_W-1:0] r_min_idx;
    logic [MIN_INDEX_W-1:0] r_cnt;
    logic                   w_hs;

    assign w_hs = (r_state == S_HOLD) && bus.score_ready;

    // Strict less-than keeps the earliest of equal scores; a clear outranks a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min     <= '1;
            r_min_idx <= '0;
            r_cnt     <= '0;
        end else if (bus.frame_clr) begin
            r_min     <= '1;
            r_min_idx <= '0;
            r_cnt     <= '0;
        end else if (w_hs) begin
            if (r_score < r_min) begin
                r_min     <= r_score;
                r_min_idx <= r_cnt;
            end
            r_cnt <= r_cnt + MIN_INDEX_W'(1);
        end
    end

    assign bus.min_score = r_min;
    assign bus.min_index = r_min_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sad_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sad_engine
//  Description : Randomised self-checking bench for sad_engine, 16-bit windows
//                in 4-bit slices, against a bit-level mismatch count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_engine;
    import sad_pkg::*;

    localparam int WB = 16;
    localparam int SB = 4;
    localparam int NS = WB / SB;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sad_engine_if #(.WIN_BITS(WB), .SLICE_BITS(SB)) bus ();

    sad_engine #(.WIN_BITS(WB), .SLICE_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [0:WB-1] m_tpl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_score(input logic [0:WB-1] w);
        int s = 0;
        for (int j = 0; j < WB; j++) if (w[j] != m_tpl[j]) s++;
        return s;
    endfunction

    function automatic logic [SB-1:0] slice_of(input logic [0:WB-1] v, input int k);
        logic [SB-1:0] d;
        for (int b = 0; b < SB; b++) d[b] = v[k*SB + b];
        return d;
    endfunction

    task automatic tpl_write(input int k, input logic [0:WB-1] v);
        bus.tpl_we   = 1'b1;
        bus.tpl_addr = 2'(k);
        bus.tpl_data = slice_of(v, k);
        tick();
        bus.tpl_we = 1'b0;
        for (int b = 0; b < SB; b++) m_tpl[k*SB + b] = v[k*SB + b];
        check("tpl_err_idle_write", bus.tpl_err, 1'b0);
    endtask

    task automatic load_tpl(input logic [0:WB-1] v);
        for (int k = 0; k < NS; k++) tpl_write(k, v);
    endtask

    task automatic run_win(input logic [0:WB-1] w, input int hold, input bit inject, input bit cap_wr);
        int lat;
        int waited;
        int exp;
        int k;
        logic [0:WB-1] v;
        waited = 0;
        while (!bus.win_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("win_ready_before_capture", bus.win_ready, 1'b1);
        if (cap_wr) begin
            k = $urandom_range(0, NS-1);
            v = WB'($urandom);
            bus.tpl_we   = 1'b1;
            bus.tpl_addr = 2'(k);
            bus.tpl_data = slice_of(v, k);
            for (int b = 0; b < SB; b++) m_tpl[k*SB + b] = v[k*SB + b];
        end
        exp = ref_score(w);
        bus.win_valid = 1'b1;
        bus.win_data  = w;
        tick();
        bus.win_valid = 1'b0;
        bus.tpl_we    = 1'b0;
        check("busy_in_accum", bus.busy, 1'b1);
        lat = 0;
        while (!bus.score_valid && lat < 20) begin
            if (inject && lat == 0) begin
                bus.tpl_we   = 1'b1;
                bus.tpl_addr = 2'($urandom_range(0, NS-1));
                bus.tpl_data = SB'($urandom);
            end
            tick();
            lat++;
            if (inject && lat == 1) begin
                bus.tpl_we = 1'b0;
                check("tpl_err_pulse", bus.tpl_err, 1'b1);
            end
            if (inject && lat == 2) check("tpl_err_cleared", bus.tpl_err, 1'b0);
        end
        check("score_latency", lat, NS);
        check("score_value", bus.score, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_score_stable", bus.score, exp);
            check("hold_valid", bus.score_valid, 1'b1);
            check("hold_win_ready_low", bus.win_ready, 1'b0);
        end
        bus.score_ready = 1'b1;
        tick();
        bus.score_ready = 1'b0;
        check("post_hs_valid_low", bus.score_valid, 1'b0);
        check("post_hs_win_ready", bus.win_ready, 1'b1);
        check("post_hs_busy_low", bus.busy, 1'b0);
    endtask

    function automatic logic [0:WB-1] ones_win(input int n);
        logic [0:WB-1] w = '0;
        for (int i = 0; i < n; i++) w[i] = 1'b1;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:WB-1] w;
        rst             = 1'b1;
        bus.tpl_we      = 1'b0;
        bus.tpl_addr    = '0;
        bus.tpl_data    = '0;
        bus.win_valid   = 1'b0;
        bus.win_data    = '0;
        bus.score_ready = 1'b0;
`ifdef SAD_MIN_TRACK_EN
        bus.frame_clr   = 1'b0;
`endif
        m_tpl = '0;
        tick();
        tick();
        check("rst_score_valid", bus.score_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_win_ready", bus.win_ready, 1'b1);
        check("rst_tpl_err", bus.tpl_err, 1'b0);
        check("rst_score", bus.score, 0);
        rst = 1'b0;
        tick();

        run_win(16'hFFFF, 0, 1'b0, 1'b0);
        load_tpl(16'hA5C3);
        run_win(16'hA5C3, 0, 1'b0, 1'b0);
        run_win(WB'($urandom), 10, 1'b0, 1'b0);
        run_win(WB'($urandom), 0, 1'b1, 1'b0);

        // Reset in the middle of accumulation.
        bus.win_valid = 1'b1;
        bus.win_data  = WB'($urandom);
        tick();
        bus.win_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_score_valid", bus.score_valid, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        tick();
        rst   = 1'b0;
        m_tpl = '0;
        tick();
        check("midrst_no_score", bus.score_valid, 1'b0);
        run_win(WB'($urandom), 1, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) tpl_write($urandom_range(0, NS-1), WB'($urandom));
            w = WB'($urandom);
            run_win(w, $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef SAD_MIN_TRACK_EN
        bus.frame_clr = 1'b1;
        tick();
        bus.frame_clr = 1'b0;
        load_tpl('0);
        run_win(ones_win(9), 0, 1'b0, 1'b0);
        run_win(ones_win(3), 0, 1'b0, 1'b0);
        run_win(ones_win(7), 0, 1'b0, 1'b0);
        run_win(ones_win(3), 0, 1'b0, 1'b0);
        check("min_score", bus.min_score, 3);
        check("min_index", bus.min_index, 1);
        bus.frame_clr = 1'b1;
        tick();
        bus.frame_clr = 1'b0;
        check("min_score_cleared", bus.min_score, 5'h1F);
        check("min_index_cleared", bus.min_index, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
